// File: rtl/memory_game_pkg.sv
// Shared types and constants for the card-matching game controller.
package memory_game_pkg;

    localparam int IDX_W     = 4;
    localparam int VAL_W     = 3;
    localparam int SCORE_W   = 4;
    localparam int TIME_W    = 4;
    localparam int MAX_CARDS = 1 << IDX_W;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P0   = 2'b01;
    localparam logic [1:0] WIN_P1   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        PICK1,
        PICK2,
        COMPARE,
        SHOW,
        DONE
    } game_state_t;

    function automatic logic [MAX_CARDS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return MAX_CARDS'(1) << idx;
    endfunction

endpackage

// File: rtl/turn_timer.sv
// Tick-enabled down-counter shared by the per-pick and face-up countdowns.
module turn_timer
    import memory_game_pkg::*;
#(
    parameter int W = TIME_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         expired
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The tick that consumes the last remaining unit is the expiry event.
    assign expired = tick && (count_q <= W'(1));
    assign count   = count_q;

endmodule

// File: rtl/memory_turn_controller.sv
// Two-player memory game sequencer: turns, picks, pair comparison, scoring and timeouts.
module memory_turn_controller
    import memory_game_pkg::*;
#(
    parameter int N_CARDS    = 16,
    parameter int TURN_TICKS = 10,
    parameter int SHOW_TICKS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               tick,
    input  logic               sel_valid,
    input  logic [IDX_W-1:0]   sel_idx,
    output logic [IDX_W-1:0]   card_idx,
    input  logic [VAL_W-1:0]   card_val,
    output logic               player,
    output logic [N_CARDS-1:0] face_up,
    output logic               match,
    output logic               mismatch,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic [TIME_W-1:0]  time_left,
    output logic               game_over,
    output logic [1:0]         winner
);

    localparam int PL_W = $clog2(N_CARDS);
    localparam logic [TIME_W-1:0] TURN_VAL = TIME_W'(TURN_TICKS);
    localparam logic [TIME_W-1:0] SHOW_VAL = TIME_W'(SHOW_TICKS);

    game_state_t        state_q, state_d;
    logic               player_q, player_d;
    logic [N_CARDS-1:0] matched_q, matched_d;
    logic [N_CARDS-1:0] revealed_q, revealed_d;
    logic [SCORE_W-1:0] score0_q, score0_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [PL_W-1:0]    pairs_left_q, pairs_left_d;
    logic [IDX_W-1:0]   idx_a_q, idx_a_d, idx_b_q, idx_b_d;
    logic [VAL_W-1:0]   val_a_q, val_a_d, val_b_q, val_b_d;

    logic               timer_tick;
    logic               timer_load;
    logic [TIME_W-1:0]  timer_val;
    logic               timer_expired;
    logic [MAX_CARDS-1:0] matched_pad;
    logic [N_CARDS-1:0] sel_mask;
    logic [N_CARDS-1:0] pair_mask;
    logic               pick_ok;
    logic               same_val;

    assign card_idx    = sel_idx;
    assign matched_pad = MAX_CARDS'(matched_q);
    assign sel_mask    = N_CARDS'(idx_onehot(sel_idx));
    assign pair_mask   = N_CARDS'(idx_onehot(idx_a_q) | idx_onehot(idx_b_q));
    assign pick_ok     = sel_valid && ({28'd0, sel_idx} < N_CARDS) && !matched_pad[sel_idx];
    assign same_val    = (val_a_q == val_b_q);

    // Ticks only count down while a pick or a face-up display is pending.
    assign timer_tick = tick && ((state_q == PICK1) || (state_q == PICK2) || (state_q == SHOW));

    turn_timer #(.W(TIME_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (timer_tick),
        .load     (timer_load),
        .load_val (timer_val),
        .count    (time_left),
        .expired  (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        player_d     = player_q;
        matched_d    = matched_q;
        revealed_d   = revealed_q;
        score0_d     = score0_q;
        score1_d     = score1_q;
        pairs_left_d = pairs_left_q;
        idx_a_d      = idx_a_q;
        val_a_d      = val_a_q;
        idx_b_d      = idx_b_q;
        val_b_d      = val_b_q;
        timer_load   = 1'b0;
        timer_val    = TURN_VAL;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    matched_d    = '0;
                    revealed_d   = '0;
                    score0_d     = '0;
                    score1_d     = '0;
                    player_d     = 1'b0;
                    pairs_left_d = PL_W'(N_CARDS / 2);
                    timer_load   = 1'b1;
                    state_d      = PICK1;
                end
            end
            PICK1: begin
                if (pick_ok) begin
                    idx_a_d    = sel_idx;
                    val_a_d    = card_val;
                    revealed_d = revealed_q | sel_mask;
                    timer_load = 1'b1;
                    state_d    = PICK2;
                end else if (timer_expired) begin
                    revealed_d = '0;
                    player_d   = ~player_q;
                    timer_load = 1'b1;
                    state_d    = PICK1;
                end
            end
            PICK2: begin
                if (pick_ok && (sel_idx != idx_a_q)) begin
                    idx_b_d    = sel_idx;
                    val_b_d    = card_val;
                    revealed_d = revealed_q | sel_mask;
                    timer_load = 1'b1;
                    state_d    = COMPARE;
                end else if (timer_expired) begin
                    revealed_d = '0;
                    player_d   = ~player_q;
                    timer_load = 1'b1;
                    state_d    = PICK1;
                end
            end
            COMPARE: begin
                if (same_val) begin
                    matched_d    = matched_q | pair_mask;
                    revealed_d   = '0;
                    pairs_left_d = pairs_left_q - PL_W'(1);
                    if (!player_q) begin
                        score0_d = (score0_q == '1) ? score0_q : score0_q + SCORE_W'(1);
                    end else begin
                        score1_d = (score1_q == '1) ? score1_q : score1_q + SCORE_W'(1);
                    end
                    if (pairs_left_q == PL_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        timer_load = 1'b1;
                        state_d    = PICK1;
                    end
                end else begin
                    timer_load = 1'b1;
                    timer_val  = SHOW_VAL;
                    state_d    = SHOW;
                end
            end
            SHOW: begin
                if (timer_expired) begin
                    revealed_d = '0;
                    player_d   = ~player_q;
                    timer_load = 1'b1;
                    state_d    = PICK1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            player_q     <= 1'b0;
            matched_q    <= '0;
            revealed_q   <= '0;
            score0_q     <= '0;
            score1_q     <= '0;
            pairs_left_q <= '0;
            idx_a_q      <= '0;
            val_a_q      <= '0;
            idx_b_q      <= '0;
            val_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            player_q     <= player_d;
            matched_q    <= matched_d;
            revealed_q   <= revealed_d;
            score0_q     <= score0_d;
            score1_q     <= score1_d;
            pairs_left_q <= pairs_left_d;
            idx_a_q      <= idx_a_d;
            val_a_q      <= val_a_d;
            idx_b_q      <= idx_b_d;
            val_b_q      <= val_b_d;
        end
    end

    for (genvar gi = 0; gi < N_CARDS; gi++) begin : g_face
        assign face_up[gi] = matched_q[gi] | revealed_q[gi];
    end

    always_comb begin
        winner = WIN_NONE;
        if (state_q == DONE) begin
            if (score0_q > score1_q) begin
                winner = WIN_P0;
            end else if (score1_q > score0_q) begin
                winner = WIN_P1;
            end else begin
                winner = WIN_TIE;
            end
        end
    end

    assign player    = player_q;
    assign match     = (state_q == COMPARE) && same_val;
    assign mismatch  = (state_q == COMPARE) && !same_val;
    assign score0    = score0_q;
    assign score1    = score1_q;
    assign game_over = (state_q == DONE);

endmodule

// File: tb/tb_memory_turn_controller.sv
// Directed bench for memory_turn_controller with a fixed board of card values.
module tb_memory_turn_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        tick;
    logic        sel_valid;
    logic [3:0]  sel_idx;
    logic [3:0]  card_idx;
    logic [2:0]  card_val;
    logic        player;
    logic [15:0] face_up;
    logic        match;
    logic        mismatch;
    logic [3:0]  score0;
    logic [3:0]  score1;
    logic [3:0]  time_left;
    logic        game_over;
    logic [1:0]  winner;

    logic [2:0]  board [16];
    int          n_checks = 0;
    int          n_fails  = 0;

    always #5 clk = ~clk;

    assign card_val = board[card_idx];

    memory_turn_controller #(
        .N_CARDS    (16),
        .TURN_TICKS (10),
        .SHOW_TICKS (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tick      (tick),
        .sel_valid (sel_valid),
        .sel_idx   (sel_idx),
        .card_idx  (card_idx),
        .card_val  (card_val),
        .player    (player),
        .face_up   (face_up),
        .match     (match),
        .mismatch  (mismatch),
        .score0    (score0),
        .score1    (score1),
        .time_left (time_left),
        .game_over (game_over),
        .winner    (winner)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pick(input logic [3:0] idx);
        sel_valid = 1'b1;
        sel_idx   = idx;
        step();
        sel_valid = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic match_pair(input logic [3:0] a, input logic [3:0] b);
        pick(a);
        pick(b);
        check("pair_match", match, 1);
        step();
    endtask

    task automatic mismatch_pair(input logic [3:0] a, input logic [3:0] b);
        pick(a);
        pick(b);
        check("pair_mismatch", mismatch, 1);
        step();
        do_tick();
        do_tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        tick      = 1'b0;
        sel_valid = 1'b0;
        sel_idx   = 4'd0;
        // Pairs: (0,7) (1,8) (2,9) (3,10) (4,11) (5,12) (6,13) (14,15)
        board = '{3'd5, 3'd2, 3'd3, 3'd0, 3'd1, 3'd4, 3'd6, 3'd5,
                  3'd2, 3'd3, 3'd0, 3'd1, 3'd4, 3'd6, 3'd7, 3'd7};
        step();
        step();

        check("rst_face_up", face_up, 0);
        check("rst_player", player, 0);
        check("rst_score0", score0, 0);
        check("rst_score1", score1, 0);
        check("rst_time_left", time_left, 0);
        check("rst_game_over", game_over, 0);
        check("rst_winner", winner, 0);
        check("rst_match", match, 0);
        check("rst_mismatch", mismatch, 0);
        sel_idx = 4'd9;
        #1;
        check("card_idx_follow", card_idx, 9);

        rst = 1'b0;
        step();
        pick(4'd3);
        check("idle_pick_face", face_up, 0);
        check("idle_time_left", time_left, 0);

        start = 1'b1;
        step();
        start = 1'b0;
        check("start_time_left", time_left, 10);
        check("start_player", player, 0);
        check("start_game_over", game_over, 0);

        do_tick();
        do_tick();
        check("tick_decrement", time_left, 8);

        // Match scenario
        pick(4'd0);
        check("pick0_face", face_up, 16'h0001);
        check("pick0_reload", time_left, 10);
        pick(4'd0);
        check("same_pick_face", face_up, 16'h0001);
        check("same_pick_time", time_left, 10);
        check("same_pick_match", match, 0);
        pick(4'd7);
        check("cmp_match", match, 1);
        check("cmp_no_mismatch", mismatch, 0);
        check("cmp_face", face_up, 16'h0081);
        check("cmp_score_early", score0, 0);
        step();
        check("post_match_pulse", match, 0);
        check("post_match_score0", score0, 1);
        check("post_match_player", player, 0);
        check("post_match_face", face_up, 16'h0081);
        check("post_match_time", time_left, 10);

        pick(4'd7);
        check("matched_pick_face", face_up, 16'h0081);
        check("matched_pick_time", time_left, 10);
        do_tick();
        pick(4'd0);
        check("matched_pick_time2", time_left, 9);

        // Mismatch scenario
        pick(4'd1);
        check("mm_pick1_face", face_up, 16'h0083);
        check("mm_pick1_time", time_left, 10);
        pick(4'd2);
        check("mm_pulse", mismatch, 1);
        check("mm_no_match", match, 0);
        check("mm_face", face_up, 16'h0087);
        step();
        check("show_time", time_left, 2);
        check("show_pulse_off", mismatch, 0);
        do_tick();
        check("show_time1", time_left, 1);
        check("show_face1", face_up, 16'h0087);
        pick(4'd3);
        check("show_pick_ignored", face_up, 16'h0087);
        do_tick();
        check("show_end_face", face_up, 16'h0081);
        check("show_end_player", player, 1);
        check("show_end_time", time_left, 10);
        check("show_end_score0", score0, 1);

        // Timeout in PICK2
        pick(4'd3);
        check("to_pick_face", face_up, 16'h0089);
        repeat (9) do_tick();
        check("to_time1", time_left, 1);
        check("to_face_before", face_up, 16'h0089);
        do_tick();
        check("to_face", face_up, 16'h0081);
        check("to_player", player, 0);
        check("to_time", time_left, 10);
        check("to_score0", score0, 1);
        check("to_score1", score1, 0);

        // Finish game: player 0 wins 5-3
        match_pair(4'd1, 4'd8);
        match_pair(4'd2, 4'd9);
        match_pair(4'd3, 4'd10);
        match_pair(4'd4, 4'd11);
        check("playing_winner", winner, 0);
        check("playing_score0", score0, 5);
        mismatch_pair(4'd5, 4'd6);
        check("handover_player", player, 1);
        match_pair(4'd5, 4'd12);
        match_pair(4'd6, 4'd13);
        match_pair(4'd14, 4'd15);
        check("g1_game_over", game_over, 1);
        check("g1_winner", winner, 2'b01);
        check("g1_score0", score0, 5);
        check("g1_score1", score1, 3);
        check("g1_face", face_up, 16'hFFFF);

        // Tie game 4-4
        start = 1'b1;
        step();
        start = 1'b0;
        check("g2_score0", score0, 0);
        check("g2_score1", score1, 0);
        check("g2_face", face_up, 0);
        check("g2_game_over", game_over, 0);
        check("g2_winner", winner, 0);
        check("g2_time", time_left, 10);
        match_pair(4'd0, 4'd7);
        match_pair(4'd1, 4'd8);
        match_pair(4'd2, 4'd9);
        match_pair(4'd3, 4'd10);
        mismatch_pair(4'd4, 4'd5);
        match_pair(4'd4, 4'd11);
        match_pair(4'd5, 4'd12);
        match_pair(4'd6, 4'd13);
        match_pair(4'd14, 4'd15);
        check("g2_end_game_over", game_over, 1);
        check("g2_end_winner", winner, 2'b11);
        check("g2_end_score0", score0, 4);
        check("g2_end_score1", score1, 4);

        start = 1'b1;
        step();
        start = 1'b0;
        check("g3_score0_clear", score0, 0);
        check("g3_score1_clear", score1, 0);
        check("g3_game_over", game_over, 0);

        // Reset while in SHOW
        mismatch_pair(4'd1, 4'd2);
        check("g3_player", player, 1);
        match_pair(4'd0, 4'd7);
        check("g3_score1", score1, 1);
        pick(4'd1);
        pick(4'd2);
        step();
        check("g3_show_time", time_left, 2);
        check("g3_show_face", face_up, 16'h0087);
        rst = 1'b1;
        #1;
        check("midrst_face", face_up, 0);
        check("midrst_player", player, 0);
        check("midrst_score1", score1, 0);
        check("midrst_time", time_left, 0);
        check("midrst_mismatch", mismatch, 0);
        check("midrst_game_over", game_over, 0);
        step();
        rst = 1'b0;
        pick(4'd0);
        check("midrst_idle_face", face_up, 0);

        // Tick and pick in the same cycle: the pick wins
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) do_tick();
        check("sim_pre_time", time_left, 7);
        tick = 1'b1;
        pick(4'd4);
        tick = 1'b0;
        check("sim_face", face_up, 16'h0010);
        check("sim_time", time_left, 10);
        repeat (9) do_tick();
        check("sim2_pre_time", time_left, 1);
        tick = 1'b1;
        pick(4'd11);
        tick = 1'b0;
        check("sim2_match", match, 1);
        step();
        check("sim2_score0", score0, 1);
        check("sim2_time", time_left, 10);
        check("sim2_player", player, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
